// File: rtl/rr_dispatch.sv
// rr_dispatch: round-robin 1:N dispatcher with a one-entry registered holding stage.
// One valid/ready input stream is spread across NUM_DST destination channels. The
// target is chosen fairly among destinations that advertise availability.
// Optional per-destination dispatch counters are built only when the macro
// RR_DISPATCH_STATS_EN is defined. Otherwise disp_cnt is tied to zero.
module rr_dispatch #(
   parameter int NUM_DST = 4,
   parameter int DATA_W  = 32
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [NUM_DST-1:0]    dst_avail,
   output logic [NUM_DST-1:0]    out_valid,
   input  logic [NUM_DST-1:0]    out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [NUM_DST*16-1:0] disp_cnt
);

   logic                 hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0]    hold_data_q,  hold_data_d;
   logic [NUM_DST-1:0]   hold_dst_q,   hold_dst_d;
   logic [NUM_DST-1:0]   last_dst_q,   last_dst_d;

   logic [NUM_DST-1:0]   drain_vec_s;
   logic                 drain_s;
   logic                 accept_s;
   logic [NUM_DST-1:0]   mask_s;
   logic [NUM_DST-1:0]   choice_s;

   // Returns a one-hot vector marking the lowest set bit of v (zero if v is zero).
   function automatic logic [NUM_DST-1:0] lowest_set(input logic [NUM_DST-1:0] v);
      logic [NUM_DST-1:0] r;
      logic               found;
      r     = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_DST; i++) begin
         if (v[i] && !found) begin
            r[i]  = 1'b1;
            found = 1'b1;
         end else begin
            r[i]  = 1'b0;
         end
      end
      return r;
   endfunction

   assign out_valid   = hold_valid_q ? hold_dst_q : '0;
   assign out_data    = hold_data_q;
   // Only the targeted destination's ready bit can drain the held beat.
   assign drain_vec_s = out_valid & out_ready;
   assign drain_s     = |drain_vec_s;
   // in_ready never depends on in_valid; the reset term keeps the input closed during reset.
   assign in_ready    = rstb & (|dst_avail) & (~hold_valid_q | drain_s);
   assign accept_s    = in_valid & in_ready;

   // Priority mask: clear positions 0..k where last_dst[k] is set, then pick the first
   // available destination above the last one, wrapping to the lowest available.
   always_comb begin
      logic seen;
      seen   = 1'b0;
      mask_s = '0;
      for (int i = NUM_DST - 1; i >= 0; i--) begin
         seen      = seen | last_dst_q[i];
         mask_s[i] = ~seen;
      end
      if (|(dst_avail & mask_s)) begin
         choice_s = lowest_set(dst_avail & mask_s);
      end else begin
         choice_s = lowest_set(dst_avail);
      end
   end

   // Next state of the holding stage: a new accept replaces the held beat, a lone drain empties it.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_dst_d   = hold_dst_q;
      last_dst_d   = last_dst_q;
      if (accept_s) begin
         hold_valid_d = 1'b1;
         hold_data_d  = in_data;
         hold_dst_d   = choice_s;
         last_dst_d   = choice_s;
      end else if (drain_s) begin
         hold_valid_d = 1'b0;
      end else begin
         hold_valid_d = hold_valid_q;
      end
   end

   // Holding stage and round-robin pointer registers; reset discards any held beat.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_dst_q   <= '0;
         last_dst_q   <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_dst_q   <= hold_dst_d;
         last_dst_q   <= last_dst_d;
      end
   end

`ifdef RR_DISPATCH_STATS_EN
   logic [NUM_DST*16-1:0] cnt_q, cnt_d;

   // Saturating per-destination drain counters.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_DST; i++) begin
         if (drain_vec_s[i] && (cnt_q[16*i +: 16] != 16'hFFFF)) begin
            cnt_d[16*i +: 16] = cnt_q[16*i +: 16] + 16'd1;
         end else begin
            cnt_d[16*i +: 16] = cnt_q[16*i +: 16];
         end
      end
   end

   // Counter registers, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign disp_cnt = cnt_q;
`else
   assign disp_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_dispatch.sv
// tb_rr_dispatch: table-driven directed bench for rr_dispatch (NUM_DST=4, DATA_W=32).
// Each table row is one clock cycle: inputs are driven after the falling edge and the
// combinational outputs are compared before the next rising edge.
module tb_rr_dispatch;

   logic        clk;
   logic        rstb;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [3:0]  dst_avail;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;
   logic [63:0] disp_cnt;

   int vectors;
   int miscompares;

   typedef struct {
      logic        rstb;
      logic        iv;
      logic [31:0] data;
      logic [3:0]  avail;
      logic [3:0]  ordy;
      logic        exp_ir;
      logic [3:0]  exp_ov;
      logic [31:0] exp_od;
   } vec_t;

   vec_t vq[$];

   rr_dispatch #(.NUM_DST(4), .DATA_W(32)) dut (
      .clk       (clk),
      .rstb      (rstb),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .dst_avail (dst_avail),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .disp_cnt  (disp_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] d,
                               input logic [3:0] av, input logic [3:0] ordy,
                               input logic eir, input logic [3:0] eov, input logic [31:0] eod);
      vec_t v;
      v.rstb = r;  v.iv = iv;  v.data = d;  v.avail = av;  v.ordy = ordy;
      v.exp_ir = eir;  v.exp_ov = eov;  v.exp_od = eod;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rstb      = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      dst_avail = 4'b0000;
      out_ready = 4'b0000;
      repeat (2) @(posedge clk);

      //            rstb  iv    data           avail    ordy     ir    ov       od
      // reset held with a valid, available input
      vq.push_back(mk(1'b0, 1'b1, 32'h0000_0011, 4'b1111, 4'b1111, 1'b0, 4'b0000, 32'h0));
      vq.push_back(mk(1'b0, 1'b1, 32'h0000_0011, 4'b1111, 4'b1111, 1'b0, 4'b0000, 32'h0));
      // fair rotation, D0..D7 back to back
      vq.push_back(mk(1'b1, 1'b1, 32'hD000_0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 32'h0));
      vq.push_back(mk(1'b1, 1'b1, 32'hD000_0001, 4'b1111, 4'b1111, 1'b1, 4'b0001, 32'hD000_0000));
      vq.push_back(mk(1'b1, 1'b1, 32'hD000_0002, 4'b1111, 4'b1111, 1'b1, 4'b0010, 32'hD000_0001));
      vq.push_back(mk(1'b1, 1'b1, 32'hD000_0003, 4'b1111, 4'b1111, 1'b1, 4'b0100, 32'hD000_0002));
      vq.push_back(mk(1'b1, 1'b1, 32'hD000_0004, 4'b1111, 4'b1111, 1'b1, 4'b1000, 32'hD000_0003));
      vq.push_back(mk(1'b1, 1'b1, 32'hD000_0005, 4'b1111, 4'b1111, 1'b1, 4'b0001, 32'hD000_0004));
      vq.push_back(mk(1'b1, 1'b1, 32'hD000_0006, 4'b1111, 4'b1111, 1'b1, 4'b0010, 32'hD000_0005));
      vq.push_back(mk(1'b1, 1'b1, 32'hD000_0007, 4'b1111, 4'b1111, 1'b1, 4'b0100, 32'hD000_0006));
      vq.push_back(mk(1'b1, 1'b0, 32'h0,         4'b1111, 4'b1111, 1'b1, 4'b1000, 32'hD000_0007));
      // move pointer to destination 1, then skip-and-wrap with avail 1001
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_0022, 4'b0010, 4'b1111, 1'b1, 4'b0000, 32'hD000_0007));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_0033, 4'b1001, 4'b1111, 1'b1, 4'b0010, 32'h0000_0022));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_0044, 4'b1001, 4'b1111, 1'b1, 4'b1000, 32'h0000_0033));
      vq.push_back(mk(1'b1, 1'b0, 32'h0,         4'b1001, 4'b1111, 1'b1, 4'b0001, 32'h0000_0044));
      // backpressure: 0xA5 held at destination 2 for five cycles
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00A5, 4'b0100, 4'b0000, 1'b1, 4'b0000, 32'h0000_0044));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00B6, 4'b1111, 4'b0000, 1'b0, 4'b0100, 32'h0000_00A5));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00B6, 4'b1111, 4'b0000, 1'b0, 4'b0100, 32'h0000_00A5));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00B6, 4'b1111, 4'b0000, 1'b0, 4'b0100, 32'h0000_00A5));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00B6, 4'b1111, 4'b1011, 1'b0, 4'b0100, 32'h0000_00A5));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00B6, 4'b1111, 4'b1011, 1'b0, 4'b0100, 32'h0000_00A5));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00B6, 4'b1111, 4'b0100, 1'b1, 4'b0100, 32'h0000_00A5));
      vq.push_back(mk(1'b1, 1'b0, 32'h0,         4'b1111, 4'b1111, 1'b1, 4'b1000, 32'h0000_00B6));
      // no availability, then restore destination 2 only
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00C7, 4'b0000, 4'b1111, 1'b0, 4'b0000, 32'h0000_00B6));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00C7, 4'b0000, 4'b1111, 1'b0, 4'b0000, 32'h0000_00B6));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00C7, 4'b0100, 4'b1111, 1'b1, 4'b0000, 32'h0000_00B6));
      // held beat drains while nothing is available
      vq.push_back(mk(1'b1, 1'b0, 32'h0,         4'b0000, 4'b1111, 1'b0, 4'b0100, 32'h0000_00C7));
      vq.push_back(mk(1'b1, 1'b0, 32'h0,         4'b0000, 4'b1111, 1'b0, 4'b0000, 32'h0000_00C7));
      // reset mid-operation discards the held beat and the pointer
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00E8, 4'b1111, 4'b1111, 1'b1, 4'b0000, 32'h0000_00C7));
      vq.push_back(mk(1'b0, 1'b1, 32'h0000_00E9, 4'b1111, 4'b0000, 1'b0, 4'b1000, 32'h0000_00E8));
      vq.push_back(mk(1'b1, 1'b0, 32'h0,         4'b1111, 4'b1111, 1'b1, 4'b0000, 32'h0));
      vq.push_back(mk(1'b1, 1'b1, 32'h0000_00F1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 32'h0));
      vq.push_back(mk(1'b1, 1'b0, 32'h0,         4'b1111, 4'b1111, 1'b1, 4'b0001, 32'h0000_00F1));

      foreach (vq[i]) begin
         @(negedge clk);
         rstb      = vq[i].rstb;
         in_valid  = vq[i].iv;
         in_data   = vq[i].data;
         dst_avail = vq[i].avail;
         out_ready = vq[i].ordy;
         #1;
         chk("in_ready",  i, {63'd0, in_ready}, {63'd0, vq[i].exp_ir});
         chk("out_valid", i, {60'd0, out_valid}, {60'd0, vq[i].exp_ov});
         chk("out_data",  i, {32'd0, out_data}, {32'd0, vq[i].exp_od});
`ifndef RR_DISPATCH_STATS_EN
         chk("disp_cnt",  i, disp_cnt, 64'd0);
`endif
      end

      // hand sequence: reset, then 65540 drains to destination 1
      @(negedge clk);
      rstb      = 1'b0;
      in_valid  = 1'b0;
      dst_avail = 4'b0010;
      out_ready = 4'b1111;
      @(negedge clk);
      rstb     = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h0000_5A5A;
      #1;
      chk("cnt_after_reset", 0, disp_cnt, 64'd0);
      repeat (65541) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("sat_out_valid", 0, {60'd0, out_valid}, {60'd0, 4'b0010});
      chk("sat_out_data",  0, {32'd0, out_data}, {32'd0, 32'h0000_5A5A});
`ifdef RR_DISPATCH_STATS_EN
      chk("sat_cnt", 0, disp_cnt, {16'h0000, 16'h0000, 16'hFFFF, 16'h0000});
`else
      chk("sat_cnt", 0, disp_cnt, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rr_dispatch.md
# rr_dispatch

Round-robin 1:N dispatcher: accepts one valid/ready input stream and routes each beat to exactly one of NUM_DST destination channels, rotating fairly among destinations that advertise availability. It is the distribution-side counterpart of our N:1 round-robin request/grant arbiter and sits in front of replicated workers or per-lane FIFOs. A one-entry registered holding stage decouples the destination choice from downstream backpressure.

## Interface
- NUM_DST, default 4: number of destination channels (≥2).
- DATA_W, default 32: payload width.
- clk  input  1  clock; all state updates on rising edge.
- rstb  input  1  reset, synchronous, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  dispatcher accepts the beat this cycle.
- in_data  input  DATA_W  input payload.
- dst_avail  input  NUM_DST  per-destination willingness (e.g. not-full), sampled only in the accept cycle.
- out_valid  output  NUM_DST  one-hot (or zero) valid, one bit per destination.
- out_ready  input  NUM_DST  per-destination ready.
- out_data  output  DATA_W  shared payload bus, meaningful only for the asserted out_valid bit.
- disp_cnt  output  NUM_DST*16  per-destination dispatch counters, destination i in bits [16*i+15:16*i].

## Operation
- State: hold_valid, hold_data[DATA_W], hold_dst[NUM_DST] one-hot, last_dst[NUM_DST] one-hot-or-zero.
- out_valid = hold_valid ? hold_dst : 0; out_data = hold_data.
- drain = |(out_valid & out_ready); out_ready bits of non-target destinations ignored.
- in_ready = rstb & (|dst_avail) & (~hold_valid | drain).
- accept = in_valid & in_ready.
- Destination choice (combinational, from dst_avail): priority mask clears bit positions 0..k where last_dst[k]=1; masked = dst_avail & mask. If masked≠0, pick lowest set bit of masked; else pick lowest set bit of dst_avail (wrap-around). last_dst=0 means destination 0 has highest priority.
- On accept: hold_valid←1, hold_data←in_data, hold_dst←choice, last_dst←choice.
- On drain without accept: hold_valid←0; hold_data/hold_dst retain values.
- Drain and accept in the same cycle: both occur; the new beat replaces the held one (full throughput).
- last_dst updates only on accept, never on drain.
- dst_avail deasserting after accept does not cancel or redirect the held beat.
- out_valid, once asserted, stays asserted with stable out_data until its out_ready is seen high.
- Upstream must hold in_valid/in_data stable while in_valid & ~in_ready (not checked here).

## Timing
- Reset (rstb low at edge): hold_valid←0, hold_data←0, hold_dst←0, last_dst←0, disp_cnt←0. Hence out_valid=0, out_data=0, disp_cnt=0 after reset; in_ready=0 while rstb is low.
- Reset mid-operation discards any held beat without handshake.
- Latency: beat accepted at edge k appears on out_valid/out_data from cycle k+1 (one cycle).
- Throughput: one beat per cycle when target out_ready is high each cycle.
- All dst_avail=0: in_ready=0, no state change; a held beat still drains normally.
- in_ready is combinational from dst_avail, out_ready, hold_valid; no combinational path from in_valid to in_ready.

## Configuration
- RR_DISPATCH_STATS_EN defined: disp_cnt[i] increments by 1 on each drain to destination i; saturates at 16'hFFFF (no wrap); cleared only by reset.
- Not defined: no counter logic; disp_cnt tied to 0. Port list identical in both builds.

## Test plan
- Reset: assert rstb=0 with in_valid=1, dst_avail=4'b1111 -> in_ready=0, out_valid=0, out_data=0 every cycle; disp_cnt=0.
- Fair rotation: NUM_DST=4, dst_avail=4'b1111, all out_ready=1, 8 back-to-back beats D0..D7 -> out_valid sequence 0001,0010,0100,1000,0001,... one per cycle, out_data=Dn one cycle after acceptance.
- Skip and wrap: last_dst=0010, dst_avail=4'b1001 -> next beat to destination 3 (1000); following beat with same avail -> destination 0 (0001).
- Backpressure: held beat 0xA5 to destination 2, out_ready=0 for 5 cycles -> out_valid=0100, out_data=0xA5 stable, in_ready=0; raise out_ready[2] -> drain and accept same cycle, new beat valid next cycle.
- No availability: dst_avail=0, in_valid=1 -> in_ready=0, last_dst unchanged; restoring dst_avail=4'b0100 -> beat accepted to destination 2.
- Stats (macro defined): force 65540 drains to destination 1 -> disp_cnt[31:16]=16'hFFFF, others 0; macro undefined -> disp_cnt=0 throughout.
